// File: rtl/polyphase_pkg.sv
// Shared types and constants for the 4x polyphase interpolator feeding the DAC TEG.
// POLYPHASE_INTERP_ROUND_EN selects the rounded, unity-gain output width.
package polyphase_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int W1 = 1;
    localparam int W2 = 2;
    localparam int W3 = 3;
    localparam int W4 = 4;

    localparam int ROUND_BIAS = 2;

    // Phase output width: BW when rounded back to unity gain, BW+2 for the raw gain-4 sum.
    function automatic int out_w(input int bw);
`ifdef POLYPHASE_INTERP_ROUND_EN
        return bw;
`else
        return bw + 2;
`endif
    endfunction

endpackage

// File: rtl/polyphase_interp_phase.sv
// One interpolation phase: K*X + (4-K)*X_Z, purely combinational.
// With POLYPHASE_INTERP_ROUND_EN the sum is rounded half-up and divided by 4.
module polyphase_interp_phase
    import polyphase_pkg::*;
#(
    parameter int K  = 1,
    parameter int BW = 6
) (
    input  logic signed [BW-1:0]        x_i,
    input  logic signed [BW-1:0]        x_z_i,
    output logic signed [out_w(BW)-1:0] y_o
);

    localparam int OW = out_w(BW);
`ifdef POLYPHASE_INTERP_ROUND_EN
    // One guard bit above the raw sum so the rounding bias cannot wrap.
    localparam int SW = BW + 3;
`else
    localparam int SW = BW + 2;
`endif

    localparam logic signed [SW-1:0] KX = SW'(K);
    localparam logic signed [SW-1:0] KZ = SW'(W4 - K);

    logic signed [SW-1:0] sum_d;

    // Weighted sum of current and previous sample, sign-extended to the working width.
    always_comb begin
        sum_d = KX * SW'(x_i) + KZ * SW'(x_z_i);
    end

`ifdef POLYPHASE_INTERP_ROUND_EN
    // Round half-up then drop the gain of 4; the result always fits BW.
    always_comb begin
        y_o = OW'((sum_d + SW'(ROUND_BIAS)) >>> 2);
    end
`else
    // Raw gain-4 sum; the range never exceeds BW+2 bits.
    always_comb begin
        y_o = sum_d;
    end
`endif

endmodule

// File: rtl/polyphase_interp4_dac_teg.sv
// 4x linear polyphase interpolator producing four parallel phases per clock
// for a 4-way time-interleaved DAC. Start-up fill, underflow flag and gap timeout.
// POLYPHASE_INTERP_ROUND_EN: outputs rounded back to BW bits (unity gain).
module polyphase_interp4_dac_teg
    import polyphase_pkg::*;
#(
    parameter int BW      = 6,
    parameter int GAP_MAX = 15
) (
    input  logic                        CLK,
    input  logic                        RES,
    input  logic                        IN_VALID,
    input  logic signed [BW-1:0]        IN,
    output logic signed [out_w(BW)-1:0] OUT1,
    output logic signed [out_w(BW)-1:0] OUT2,
    output logic signed [out_w(BW)-1:0] OUT3,
    output logic signed [out_w(BW)-1:0] OUT4,
    output logic                        OUT_VALID,
    output logic                        UFLOW,
    output logic                        ACTIVE
);

    localparam int             OW      = out_w(BW);
    localparam logic [7:0]     GAP_LIM = 8'(GAP_MAX);

    state_t               state_q;
    logic signed [BW-1:0] x_z_q;
    logic [7:0]           gap_q;
    logic signed [OW-1:0] out1_q, out2_q, out3_q, out4_q;
    logic                 out_valid_q, uflow_q, active_q;
    logic signed [OW-1:0] ph1_d, ph2_d, ph3_d, ph4_d;

    polyphase_interp_phase #(.K(W1), .BW(BW)) u_ph1 (.x_i(IN), .x_z_i(x_z_q), .y_o(ph1_d));
    polyphase_interp_phase #(.K(W2), .BW(BW)) u_ph2 (.x_i(IN), .x_z_i(x_z_q), .y_o(ph2_d));
    polyphase_interp_phase #(.K(W3), .BW(BW)) u_ph3 (.x_i(IN), .x_z_i(x_z_q), .y_o(ph3_d));
    polyphase_interp_phase #(.K(W4), .BW(BW)) u_ph4 (.x_i(IN), .x_z_i(x_z_q), .y_o(ph4_d));

    // Control FSM with all outputs registered; IDLE primes X_Z, FILL emits the first set.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q     <= IDLE;
            x_z_q       <= '0;
            gap_q       <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            out3_q      <= '0;
            out4_q      <= '0;
            out_valid_q <= 1'b0;
            uflow_q     <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    uflow_q     <= 1'b0;
                    if (IN_VALID) begin
                        x_z_q   <= IN;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    uflow_q <= 1'b0;
                    if (IN_VALID) begin
                        out1_q      <= ph1_d;
                        out2_q      <= ph2_d;
                        out3_q      <= ph3_d;
                        out4_q      <= ph4_d;
                        x_z_q       <= IN;
                        out_valid_q <= 1'b1;
                        active_q    <= 1'b1;
                        gap_q       <= '0;
                        state_q     <= RUN;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (IN_VALID) begin
                        out1_q      <= ph1_d;
                        out2_q      <= ph2_d;
                        out3_q      <= ph3_d;
                        out4_q      <= ph4_d;
                        x_z_q       <= IN;
                        out_valid_q <= 1'b1;
                        uflow_q     <= 1'b0;
                        gap_q       <= '0;
                    end else begin
                        out_valid_q <= 1'b0;
                        uflow_q     <= (gap_q == 8'd0);
                        if (gap_q + 8'd1 == GAP_LIM) begin
                            // Stream considered dead: park the DAC at zero.
                            out1_q   <= '0;
                            out2_q   <= '0;
                            out3_q   <= '0;
                            out4_q   <= '0;
                            x_z_q    <= '0;
                            gap_q    <= '0;
                            active_q <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            gap_q <= gap_q + 8'd1;
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    uflow_q     <= 1'b0;
                    active_q    <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign OUT1      = out1_q;
    assign OUT2      = out2_q;
    assign OUT3      = out3_q;
    assign OUT4      = out4_q;
    assign OUT_VALID = out_valid_q;
    assign UFLOW     = uflow_q;
    assign ACTIVE    = active_q;

endmodule
